// File: rtl/alu_stim_seq_if.sv
// Handshake bus between the vector sequencer and the ALU input stage.
interface alu_stim_seq_if #(
  parameter int WIDTH = 7,
  parameter int OPW   = 2
);
  logic             start;
  logic [1:0]       mode;
  logic [OPW-1:0]   op_sel;
  logic             ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [OPW-1:0]   OP;
  logic             valid;
  logic             busy;
  logic             done;

  modport master (
    input  start, mode, op_sel, ready,
    output A, B, OP, valid, busy, done
  );

  modport slave (
    output start, mode, op_sel, ready,
    input  A, B, OP, valid, busy, done
  );
endinterface

// File: rtl/alu_stim_seq.sv
// Operand/opcode vector sequencer: sweep, Galois-LFSR and fixed-op modes,
// valid/ready output handshake, VEC_COUNT vectors per run.
module alu_stim_seq #(
  parameter int               WIDTH     = 7,
  parameter int               OPW       = 2,
  parameter int               VEC_COUNT = 16,
  parameter logic [WIDTH-1:0] SEED      = 7'h01,
  parameter logic [WIDTH-1:0] TAPS      = 7'h60
) (
  input  logic                               clk,
  input  logic                               rst,
  alu_stim_seq_if.master                     bus,
  output logic [$clog2(VEC_COUNT+1)-1:0]     vec_cnt
);
  localparam int            CW   = $clog2(VEC_COUNT+1);
  localparam logic [CW-1:0] LAST = CW'(VEC_COUNT-1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [1:0] M_SWEEP = 2'b00;
  localparam logic [1:0] M_LFSR  = 2'b01;
  localparam logic [1:0] M_FIXED = 2'b10;

  state_t           state_q, state_d;
  logic             ld_first, ld_next, xfer;
  logic [1:0]       mode_in, mode_q;
  logic [OPW-1:0]   opc_q, op_q;
  logic [WIDTH-1:0] lfsr_q, lfsr_nx, a_q, b_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] fa, fb, na, nb;
  logic [OPW-1:0]   fop, nop;

  function automatic logic [WIDTH-1:0] rol1(input logic [WIDTH-1:0] v);
    return {v[WIDTH-2:0], v[WIDTH-1]};
  endfunction

  // mode 11 is an alias of sweep; fold it once so downstream only sees three modes
  assign mode_in = (bus.mode == 2'b11) ? M_SWEEP : bus.mode;
  // valid is exactly "in RUN", so a transfer needs only ready
  assign xfer    = (state_q == RUN) && bus.ready;
  assign lfsr_nx = {1'b0, lfsr_q[WIDTH-1:1]} ^ (lfsr_q[0] ? TAPS : '0);

  // first vector of a run, from the mode/op being captured this edge
  always_comb begin
    fa  = '0;
    fb  = '1;
    fop = '0;
    case (mode_in)
      M_LFSR: begin
        fa  = SEED;
        fb  = rol1(SEED);
        fop = SEED[OPW-1:0];
      end
      M_FIXED: fop = bus.op_sel;
      default: ;
    endcase
  end

  // successor of the vector currently on the outputs
  always_comb begin
    na  = a_q;
    nb  = ~a_q;
    nop = op_q;
    case (mode_q)
      M_LFSR: begin
        na  = lfsr_nx;
        nb  = rol1(lfsr_nx);
        nop = lfsr_nx[OPW-1:0];
      end
      M_FIXED: begin
        na  = a_q + 1'b1;
        nb  = ~(a_q + 1'b1);
        nop = opc_q;
      end
      default: begin
        nop = op_q + 1'b1;
        if (op_q == '1) begin
          na = a_q + 1'b1;
          nb = ~(a_q + 1'b1);
        end
      end
    endcase
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // next state and load strobes; start is only looked at outside RUN
  always_comb begin
    state_d  = state_q;
    ld_first = 1'b0;
    ld_next  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d  = RUN;
          ld_first = 1'b1;
        end
      end
      RUN: begin
        if (bus.ready) begin
          if (cnt_q == LAST) state_d = DONE;
          else               ld_next = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // vector, LFSR, captured config and transfer counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      lfsr_q <= SEED;
      mode_q <= M_SWEEP;
      opc_q  <= '0;
      cnt_q  <= '0;
    end else if (ld_first) begin
      a_q    <= fa;
      b_q    <= fb;
      op_q   <= fop;
      lfsr_q <= SEED;
      mode_q <= mode_in;
      opc_q  <= bus.op_sel;
      cnt_q  <= '0;
    end else if (xfer) begin
      cnt_q <= cnt_q + 1'b1;
      if (ld_next) begin
        a_q    <= na;
        b_q    <= nb;
        op_q   <= nop;
        lfsr_q <= lfsr_nx;
      end
    end
  end

  assign bus.A     = a_q;
  assign bus.B     = b_q;
  assign bus.OP    = op_q;
  assign bus.valid = (state_q == RUN);
  assign bus.busy  = (state_q == RUN);
  assign bus.done  = (state_q == DONE);
  assign vec_cnt   = cnt_q;
endmodule
